uart_regfile_arbiter: RTL and testbench

Owns the 8x4 register file that the UART command link reads and writes. Arbitrates register access between two requesters: decoded UART Rx commands and a local requester (debug/switch port). Queues each UART reply ({addr, data}) and sequences it into the UART transmitter with a start/busy handshake. Counts UART commands that are discarded because of parity errors.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_reply_fifo.sv | 52 +++++
 rtl/uart_regfile_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_uart_regfile_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART register-file slice: default widths,
// read/write encoding, reply frame width and the FSM state encodings.
package uart_pkg;

  localparam int ADDR_W_DEF      = 3;
  localparam int DATA_W_DEF      = 4;
  localparam int REPLY_DEPTH_DEF = 4;

  // A reply frame is {addr, data}.
  localparam int FRAME_W_DEF = ADDR_W_DEF + DATA_W_DEF;

  // Command direction bit as carried on rx_cmd_rw / loc_rw.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Parity-error counter width and saturation value.
  localparam int         ERR_CNT_W   = 8;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Register-access arbiter: every grant occupies IDLE then ACCESS.
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_t;

  // Reply sequencer towards the UART transmitter.
  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_WAIT_BUSY = 2'd1,
    TX_WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_reply_fifo.sv
// Synchronous reply FIFO. Full/empty come from pointers carrying one extra
// wrap bit. A pop on a full FIFO frees the slot so a same-cycle push lands;
// a push into an empty FIFO is not bypassed to dout.
module uart_reply_fifo #(
  parameter int WIDTH = uart_pkg::FRAME_W_DEF,
  parameter int DEPTH = uart_pkg::REPLY_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  assign dout = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; both wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_regfile_arbiter.sv
// Register file shared by the UART command link and a local requester.
// A round-robin arbiter grants one access at a time (IDLE -> ACCESS, two
// cycles per grant); rx replies are queued and sequenced into the UART Tx.
//
// Handshakes: rx side is valid/ready -- the command transfers in any cycle
// where rx_cmd_valid & rx_cmd_ready, and the source holds its fields stable
// while valid is high and ready is low. Local side is req/gnt -- loc_req is
// held until the one-cycle loc_gnt; loc_done pulses one cycle later with
// loc_rdata valid. Tx side: tx_start pulses with tx_frame valid, then the
// sequencer waits for tx_busy to rise and fall before the next frame.
module uart_regfile_arbiter
  import uart_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REPLY_DEPTH = REPLY_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_cmd_valid,
  input  logic                     rx_cmd_rw,
  input  logic [ADDR_W-1:0]        rx_cmd_addr,
  input  logic [DATA_W-1:0]        rx_cmd_data,
  input  logic                     rx_cmd_perr,
  output logic                     rx_cmd_ready,
  input  logic                     loc_req,
  input  logic                     loc_rw,
  input  logic [ADDR_W-1:0]        loc_addr,
  input  logic [DATA_W-1:0]        loc_wdata,
  output logic                     loc_gnt,
  output logic                     loc_done,
  output logic [DATA_W-1:0]        loc_rdata,
  output logic                     tx_start,
  output logic [ADDR_W+DATA_W-1:0] tx_frame,
  input  logic                     tx_busy,
  output logic [ERR_CNT_W-1:0]     err_cnt,
  output arb_state_t               dbg_arb_state,
  output tx_state_t                dbg_tx_state
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int NREG    = 1 << ADDR_W;

  // Arbiter state and the latched winning command.
  arb_state_t          r_arb_state;
  arb_state_t          w_arb_next;
  logic                r_rr_loc;      // 1: next contested grant goes to local
  logic                r_org_loc;     // command in ACCESS came from local
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic [DATA_W-1:0]   r_file [NREG];
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [DATA_W-1:0]   r_loc_rdata;

  tx_state_t           r_tx_state;
  tx_state_t           w_tx_next;
  logic [FRAME_W-1:0]  r_tx_frame;

  logic                w_rx_elig;
  logic                w_rx_ready;
  logic                w_rx_acc;
  logic                w_loc_gnt;
  logic                w_access;
  logic [DATA_W-1:0]   w_rd_val;
  logic [DATA_W-1:0]   w_loc_val;
  logic                w_loc_done;
  logic                w_push;
  logic [FRAME_W-1:0]  w_push_data;
  logic                w_pop;
  logic [FRAME_W-1:0]  w_fifo_dout;
  logic                w_fifo_full;
  logic                w_fifo_empty;

  assign w_rx_elig = rx_cmd_valid & ~w_fifo_full;

  // Arbiter next state and grant decode; a parity-error command is accepted
  // but never enters ACCESS.
  always_comb begin
    w_arb_next = r_arb_state;
    w_rx_ready = 1'b0;
    w_loc_gnt  = 1'b0;
    case (r_arb_state)
      ARB_IDLE: begin
        w_rx_ready = ~w_fifo_full & (~r_rr_loc | ~loc_req);
        w_loc_gnt  = loc_req & (r_rr_loc | ~w_rx_elig);
        if ((rx_cmd_valid & w_rx_ready & ~rx_cmd_perr) | w_loc_gnt)
          w_arb_next = ARB_ACCESS;
      end
      ARB_ACCESS: w_arb_next = ARB_IDLE;
      default:    w_arb_next = ARB_IDLE;
    endcase
  end

  assign w_rx_acc = rx_cmd_valid & w_rx_ready;

  // Arbiter state, round-robin pointer and command latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arb_state <= ARB_IDLE;
      r_rr_loc    <= 1'b0;
      r_org_loc   <= 1'b0;
      r_rw        <= RW_WRITE;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_arb_state <= w_arb_next;
      if (w_rx_acc | w_loc_gnt) r_rr_loc <= ~r_rr_loc;
      if (w_loc_gnt) begin
        r_org_loc <= 1'b1;
        r_rw      <= loc_rw;
        r_addr    <= loc_addr;
        r_wdata   <= loc_wdata;
      end else if (w_rx_acc && !rx_cmd_perr) begin
        r_org_loc <= 1'b0;
        r_rw      <= rx_cmd_rw;
        r_addr    <= rx_cmd_addr;
        r_wdata   <= rx_cmd_data;
      end
    end
  end

  // ACCESS datapath: read value, local completion, rx reply.
  assign w_access    = (r_arb_state == ARB_ACCESS);
  assign w_rd_val    = r_file[r_addr];
  assign w_loc_val   = (r_rw == RW_READ) ? w_rd_val : r_wdata;
  assign w_loc_done  = w_access & r_org_loc;
  assign w_push      = w_access & ~r_org_loc;
  assign w_push_data = {r_addr, (r_rw == RW_READ) ? w_rd_val : {DATA_W{1'b0}}};

  // Register file: writes commit at the end of ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_file[i] <= '0;
    end else if (w_access && r_rw == RW_WRITE) begin
      r_file[r_addr] <= r_wdata;
    end
  end

  // Hold the last local result and count parity-error commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_loc_rdata <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_loc_done) r_loc_rdata <= w_loc_val;
      if (w_rx_acc && rx_cmd_perr && r_err_cnt != ERR_CNT_MAX)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  uart_reply_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (REPLY_DEPTH)
  ) u_reply_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_push_data),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Tx sequencer next state: pop and start, then track one busy period.
  always_comb begin
    w_tx_next = r_tx_state;
    w_pop     = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (!w_fifo_empty && !tx_busy) begin
          w_pop     = 1'b1;
          w_tx_next = TX_WAIT_BUSY;
        end
      end
      TX_WAIT_BUSY: if (tx_busy)  w_tx_next = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!tx_busy) w_tx_next = TX_IDLE;
      default:      w_tx_next = TX_IDLE;
    endcase
  end

  // Tx state register and frame hold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_frame <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_pop) r_tx_frame <= w_fifo_dout;
    end
  end

  assign rx_cmd_ready  = w_rx_ready;
  assign loc_gnt       = w_loc_gnt;
  assign loc_done      = w_loc_done;
  assign loc_rdata     = w_loc_done ? w_loc_val : r_loc_rdata;
  assign tx_start      = w_pop;
  assign tx_frame      = w_pop ? w_fifo_dout : r_tx_frame;
  assign err_cnt       = r_err_cnt;
  assign dbg_arb_state = r_arb_state;
  assign dbg_tx_state  = r_tx_state;

endmodule

// File: tb/tb_uart_regfile_arbiter.sv
// Directed bench for uart_regfile_arbiter: rx/local accesses, arbitration
// order, parity-error counting, reply back-pressure and mid-access reset.
module tb_uart_regfile_arbiter;
  import uart_pkg::*;

  localparam int AW = 3;
  localparam int DW = 4;
  localparam int FW = AW + DW;
  localparam int WAIT_LIMIT = 50;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          rx_cmd_valid = 1'b0;
  logic          rx_cmd_rw    = 1'b0;
  logic [AW-1:0] rx_cmd_addr  = '0;
  logic [DW-1:0] rx_cmd_data  = '0;
  logic          rx_cmd_perr  = 1'b0;
  logic          rx_cmd_ready;
  logic          loc_req      = 1'b0;
  logic          loc_rw       = 1'b0;
  logic [AW-1:0] loc_addr     = '0;
  logic [DW-1:0] loc_wdata    = '0;
  logic          loc_gnt;
  logic          loc_done;
  logic [DW-1:0] loc_rdata;
  logic          tx_start;
  logic [FW-1:0] tx_frame;
  wire           tx_busy;
  logic [7:0]    err_cnt;
  arb_state_t    dbg_arb_state;
  tx_state_t     dbg_tx_state;

  logic hold_busy  = 1'b0;
  logic model_busy = 1'b0;
  assign tx_busy = hold_busy | model_busy;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] got_q[$];
  int n_pass  = 0;
  int n_total = 0;

  uart_regfile_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .rx_cmd_valid  (rx_cmd_valid),
    .rx_cmd_rw     (rx_cmd_rw),
    .rx_cmd_addr   (rx_cmd_addr),
    .rx_cmd_data   (rx_cmd_data),
    .rx_cmd_perr   (rx_cmd_perr),
    .rx_cmd_ready  (rx_cmd_ready),
    .loc_req       (loc_req),
    .loc_rw        (loc_rw),
    .loc_addr      (loc_addr),
    .loc_wdata     (loc_wdata),
    .loc_gnt       (loc_gnt),
    .loc_done      (loc_done),
    .loc_rdata     (loc_rdata),
    .tx_start      (tx_start),
    .tx_frame      (tx_frame),
    .tx_busy       (tx_busy),
    .err_cnt       (err_cnt),
    .dbg_arb_state (dbg_arb_state),
    .dbg_tx_state  (dbg_tx_state)
  );

  // UART Tx stand-in: capture each started frame, then stay busy 3 cycles.
  initial begin : tx_model
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        got_q.push_back(tx_frame);
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  // Watchdog
  initial begin : watchdog
    #200000;
    $error("FAIL watchdog: observed no end of test, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_total++;
    $error("FAIL %s: observed no handshake, expected one within %0d cycles", tag, WAIT_LIMIT);
  endtask

  // Present an rx command, wait for acceptance, return in the following cycle.
  task automatic rx_send(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic perr, input string tag);
    int k;
    rx_cmd_valid = 1'b1;
    rx_cmd_rw    = rw;
    rx_cmd_addr  = a;
    rx_cmd_data  = d;
    rx_cmd_perr  = perr;
    #1;
    k = 0;
    while (rx_cmd_ready !== 1'b1 && k < WAIT_LIMIT) begin
      step();
      #1;
      k++;
    end
    if (k == WAIT_LIMIT) timeout_fail(tag);
    step();
    rx_cmd_valid = 1'b0;
    rx_cmd_perr  = 1'b0;
    #1;
  endtask

  // Local access: wait for loc_gnt, then check loc_done/loc_rdata in ACCESS.
  task automatic loc_access(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] exp_rdata, input string tag);
    int k;
    loc_req   = 1'b1;
    loc_rw    = rw;
    loc_addr  = a;
    loc_wdata = d;
    #1;
    k = 0;
    while (loc_gnt !== 1'b1 && k < WAIT_LIMIT) begin
      step();
      #1;
      k++;
    end
    if (k == WAIT_LIMIT) timeout_fail(tag);
    step();
    loc_req = 1'b0;
    #1;
    check({tag, "_done"}, 32'(loc_done), 32'd1);
    check({tag, "_rdata"}, 32'(loc_rdata), 32'(exp_rdata));
  endtask

  // Scoreboard: compare captured frames against the expected queue, in order.
  task automatic check_frames(input string tag);
    check({tag, "_frame_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_frame%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin : stimulus
    // Reset
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("rst_rx_ready", 32'(rx_cmd_ready), 32'd1);
    check("rst_loc_gnt", 32'(loc_gnt), 32'd0);
    check("rst_loc_done", 32'(loc_done), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_loc_rdata", 32'(loc_rdata), 32'd0);
    check("rst_tx_frame", 32'(tx_frame), 32'd0);
    check("rst_arb_state", 32'(dbg_arb_state), 32'(ARB_IDLE));
    check("rst_tx_state", 32'(dbg_tx_state), 32'(TX_IDLE));

    // rx write then read of addr 2
    rx_send(RW_WRITE, 3'd2, 4'b0101, 1'b0, "t1_wr");
    check("t1_access_state", 32'(dbg_arb_state), 32'(ARB_ACCESS));
    rx_send(RW_READ, 3'd2, 4'b0000, 1'b0, "t1_rd");
    exp_q.push_back(7'b010_0000);
    exp_q.push_back(7'b010_0101);
    repeat (30) step();
    check_frames("t1");
    check("t1_err_cnt", 32'(err_cnt), 32'd0);

    // Preload addr1=0010 (local), addr4=1001 (rx); pointer ends favouring rx
    loc_access(RW_WRITE, 3'd1, 4'b0010, 4'b0010, "t2_pre_loc");
    step();
    rx_send(RW_WRITE, 3'd4, 4'b1001, 1'b0, "t2_pre_rx");
    exp_q.push_back(7'b100_0000);
    step();

    // Both requesters read addr1 continuously; grants alternate rx, loc, rx, loc
    rx_cmd_valid = 1'b1; rx_cmd_rw = RW_READ; rx_cmd_addr = 3'd1; rx_cmd_data = '0;
    loc_req = 1'b1; loc_rw = RW_READ; loc_addr = 3'd1; loc_wdata = '0;
    #1;
    check("t2_c0_rx_ready", 32'(rx_cmd_ready), 32'd1);
    check("t2_c0_loc_gnt", 32'(loc_gnt), 32'd0);
    step(); #1;
    check("t2_c1_rx_ready", 32'(rx_cmd_ready), 32'd0);
    check("t2_c1_loc_gnt", 32'(loc_gnt), 32'd0);
    step(); #1;
    check("t2_c2_loc_gnt", 32'(loc_gnt), 32'd1);
    check("t2_c2_rx_ready", 32'(rx_cmd_ready), 32'd0);
    step(); #1;
    check("t2_c3_loc_done", 32'(loc_done), 32'd1);
    check("t2_c3_loc_rdata", 32'(loc_rdata), 32'b0010);
    step(); #1;
    check("t2_c4_rx_ready", 32'(rx_cmd_ready), 32'd1);
    check("t2_c4_loc_gnt", 32'(loc_gnt), 32'd0);
    step(); #1;
    step(); #1;
    check("t2_c6_loc_gnt", 32'(loc_gnt), 32'd1);
    step();
    rx_cmd_valid = 1'b0;
    loc_req = 1'b0;
    #1;
    check("t2_c7_loc_done", 32'(loc_done), 32'd1);
    exp_q.push_back(7'b001_0010);
    exp_q.push_back(7'b001_0010);
    repeat (30) step();
    check_frames("t2");

    // Local write addr7=1111, rx read addr7 the cycle after loc_done
    loc_access(RW_WRITE, 3'd7, 4'b1111, 4'b1111, "t3_loc_wr");
    step();
    rx_send(RW_READ, 3'd7, 4'b0000, 1'b0, "t3_rd");
    exp_q.push_back(7'b111_1111);
    repeat (15) step();
    check_frames("t3");

    // Parity errors: no access, no reply, saturating count
    rx_send(RW_WRITE, 3'd3, 4'b1010, 1'b1, "t4_perr");
    check("t4_no_access", 32'(dbg_arb_state), 32'(ARB_IDLE));
    check("t4_err_cnt1", 32'(err_cnt), 32'd1);
    rx_cmd_valid = 1'b1; rx_cmd_perr = 1'b1; rx_cmd_rw = RW_WRITE;
    rx_cmd_addr = 3'd3; rx_cmd_data = 4'b1010;
    repeat (253) step();
    rx_cmd_valid = 1'b0;
    #1;
    check("t4_err_cnt254", 32'(err_cnt), 32'd254);
    rx_cmd_valid = 1'b1;
    repeat (46) step();
    rx_cmd_valid = 1'b0; rx_cmd_perr = 1'b0;
    #1;
    check("t4_err_cnt_sat", 32'(err_cnt), 32'd255);
    step();
    loc_access(RW_READ, 3'd3, 4'b0000, 4'b0000, "t4_file3");
    repeat (10) step();
    check_frames("t4");

    // Back-pressure: Tx held busy, 4 replies fill the FIFO, 5th stalls
    hold_busy = 1'b1;
    rx_send(RW_READ, 3'd1, 4'b0000, 1'b0, "t5_rd0");
    rx_send(RW_READ, 3'd2, 4'b0000, 1'b0, "t5_rd1");
    rx_send(RW_READ, 3'd7, 4'b0000, 1'b0, "t5_rd2");
    rx_send(RW_READ, 3'd0, 4'b0000, 1'b0, "t5_rd3");
    step();
    rx_cmd_valid = 1'b1; rx_cmd_rw = RW_READ; rx_cmd_addr = 3'd4;
    #1;
    check("t5_full_ready", 32'(rx_cmd_ready), 32'd0);
    check("t5_held_tx_start", 32'(tx_start), 32'd0);
    step(); step(); #1;
    check("t5_full_ready_later", 32'(rx_cmd_ready), 32'd0);
    step();
    hold_busy = 1'b0;
    #1;
    check("t5_pop_tx_start", 32'(tx_start), 32'd1);
    check("t5_pop_frame", 32'(tx_frame), 32'(7'b001_0010));
    check("t5_pop_ready", 32'(rx_cmd_ready), 32'd0);
    step(); #1;
    check("t5_after_pop_ready", 32'(rx_cmd_ready), 32'd1);
    step();
    rx_cmd_valid = 1'b0;
    exp_q.push_back(7'b001_0010);
    exp_q.push_back(7'b010_0101);
    exp_q.push_back(7'b111_1111);
    exp_q.push_back(7'b000_0000);
    exp_q.push_back(7'b100_1001);
    repeat (50) step();
    check_frames("t5");

    // Reset in ACCESS with two replies queued
    loc_access(RW_READ, 3'd7, 4'b0000, 4'b1111, "t6_pre_rd");
    hold_busy = 1'b1;
    step();
    rx_send(RW_WRITE, 3'd5, 4'b0011, 1'b0, "t6_wr5");
    rx_send(RW_WRITE, 3'd6, 4'b0110, 1'b0, "t6_wr6");
    rx_send(RW_READ, 3'd7, 4'b0000, 1'b0, "t6_rd7");
    check("t6_in_access", 32'(dbg_arb_state), 32'(ARB_ACCESS));
    rst = 1'b1;
    step(); #1;
    check("t6_loc_gnt", 32'(loc_gnt), 32'd0);
    check("t6_loc_done", 32'(loc_done), 32'd0);
    check("t6_tx_start", 32'(tx_start), 32'd0);
    check("t6_err_cnt", 32'(err_cnt), 32'd0);
    check("t6_loc_rdata", 32'(loc_rdata), 32'd0);
    check("t6_tx_frame", 32'(tx_frame), 32'd0);
    check("t6_rx_ready", 32'(rx_cmd_ready), 32'd1);
    check("t6_arb_state", 32'(dbg_arb_state), 32'(ARB_IDLE));
    rst = 1'b0;
    hold_busy = 1'b0;
    repeat (20) step();
    check_frames("t6");
    loc_access(RW_READ, 3'd5, 4'b0000, 4'b0000, "t6_file5");
    step();
    loc_access(RW_READ, 3'd7, 4'b0000, 4'b0000, "t6_file7");
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
